instruction_fetch_unit: RTL and testbench

Front end of the ARMv8 datapath. Holds the PC and issues word fetches to instruction memory over a req/ack handshake. Buffers one fetched instruction for decode, where Instruction[25:0] drives the immediate extender's Imm26 input. It also consumes the extender's BusImm from the execute stage to compute branch targets and redirect fetch.

---
 rtl/instruction_fetch_unit_pkg.sv | 20 ++
 rtl/instruction_fetch_unit_if.sv | 30 +++
 rtl/instruction_fetch_unit_next_pc_calc.sv | 17 +
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10
  } ifu_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // Branch-type codes, same encoding as the immediate extender's Ctrl input.
  localparam logic [2:0] CTRL_B  = 3'b010;
  localparam logic [2:0] CTRL_CB = 3'b011;

  function automatic logic [63:0] word_offset(input logic [63:0] imm);
    return {imm[61:0], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory, decode and branch-resolution signals seen by the fetch unit.
interface instruction_fetch_unit_if;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic [31:0] Instruction;
  logic [25:0] Imm26;
  logic [63:0] InstrPC;
  logic        InstrValid;
  logic        DecodeReady;
  logic        BrValid;
  logic [63:0] BrPC;
  logic [63:0] BusImm;
  logic        Uncondbranch;
  logic        Branch;
  logic        Zero;

  modport master (
    output ImemReq, ImemAddr, Instruction, Imm26, InstrPC, InstrValid,
    input  ImemAck, ImemData, DecodeReady, BrValid, BrPC, BusImm,
           Uncondbranch, Branch, Zero
  );

  modport slave (
    input  ImemReq, ImemAddr, Instruction, Imm26, InstrPC, InstrValid,
    output ImemAck, ImemData, DecodeReady, BrValid, BrPC, BusImm,
           Uncondbranch, Branch, Zero
  );
endinterface

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Branch resolution: decides whether the executing branch redirects fetch and where to.
module next_pc_calc
  import instruction_fetch_unit_pkg::*;
(
  input  logic        BrValid,
  input  logic        Uncondbranch,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [63:0] BrPC,
  input  logic [63:0] BusImm,
  output logic        Taken,
  output logic [63:0] Target
);
  assign Taken  = BrValid & (Uncondbranch | (Branch & Zero));
  // Modulo 2^64: wrap-around is architecturally allowed.
  assign Target = BrPC + word_offset(BusImm);
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC, fetch request FSM and one-entry instruction buffer feeding decode.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [63:0] StartPC = 64'h0
)(
  input  logic                         CLK,
  input  logic                         Reset,
  instruction_fetch_unit_if.master     bus
);

  ifu_state_e  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  logic        taken;
  logic [63:0] target;
  logic        req;
  logic        ack;
  logic        consume;

  next_pc_calc u_next_pc (
    .BrValid      (bus.BrValid),
    .Uncondbranch (bus.Uncondbranch),
    .Branch       (bus.Branch),
    .Zero         (bus.Zero),
    .BrPC         (bus.BrPC),
    .BusImm       (bus.BusImm),
    .Taken        (taken),
    .Target       (target)
  );

  assign req     = ((state_q == FETCH) || (state_q == DRAIN)) && !Reset;
  assign ack     = bus.ImemAck & req;
  assign consume = instr_valid_q & bus.DecodeReady;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    if (taken) begin
      // Any data acked this cycle belongs to the wrong path and is dropped.
      pc_d          = target;
      instr_valid_d = 1'b0;
      unique case (state_q)
        FETCH:   state_d = ack ? IDLE : DRAIN;
        DRAIN:   state_d = ack ? IDLE : DRAIN;
        default: state_d = IDLE;
      endcase
    end else begin
      if (consume) instr_valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!instr_valid_q || consume) begin
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        FETCH: begin
          if (ack) begin
            instr_d       = bus.ImemData;
            instr_pc_d    = req_addr_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 64'(INSTR_BYTES);
            state_d       = IDLE;
          end
        end
        DRAIN: begin
          if (ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= IDLE;
      pc_q          <= StartPC;
      req_addr_q    <= 64'h0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 64'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.ImemReq     = req;
  assign bus.ImemAddr    = req ? req_addr_q : 64'h0;
  assign bus.Instruction = instr_q;
  assign bus.Imm26       = instr_q[25:0];
  assign bus.InstrPC     = instr_pc_q;
  assign bus.InstrValid  = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory ack is driven by hand per step.
module tb_instruction_fetch_unit;

  logic CLK = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.StartPC(64'h0)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_br();
    bus.BrValid = 0; bus.Uncondbranch = 0; bus.Branch = 0; bus.Zero = 0;
    bus.BrPC = '0; bus.BusImm = '0;
  endtask

  initial begin
    Reset = 1;
    bus.ImemAck = 0; bus.ImemData = '0; bus.DecodeReady = 1;
    clear_br();
    tick(); tick();
    chk("rst_req",   {63'b0, bus.ImemReq}, 64'h0);
    chk("rst_addr",  bus.ImemAddr, 64'h0);
    chk("rst_valid", {63'b0, bus.InstrValid}, 64'h0);
    chk("rst_instr", {32'b0, bus.Instruction}, 64'h0);

    // 1: first fetch at StartPC, 1-cycle ack
    Reset = 0;
    tick();
    chk("t1_req",  {63'b0, bus.ImemReq}, 64'h1);
    chk("t1_addr", bus.ImemAddr, 64'h0);
    bus.ImemAck = 1; bus.ImemData = 32'h91000421;
    tick();
    bus.ImemAck = 0;
    chk("t1_instr", {32'b0, bus.Instruction}, 64'h91000421);
    chk("t1_imm26", {38'b0, bus.Imm26}, 64'h1000421);
    chk("t1_ipc",   bus.InstrPC, 64'h0);
    chk("t1_valid", {63'b0, bus.InstrValid}, 64'h1);
    chk("t1_req0",  {63'b0, bus.ImemReq}, 64'h0);
    tick();
    chk("t1_next",   bus.ImemAddr, 64'h4);
    chk("t1_vclr",   {63'b0, bus.InstrValid}, 64'h0);

    // 2: decode stall holds the buffer; stray ack while idle is ignored
    bus.DecodeReady = 0; bus.ImemAck = 1; bus.ImemData = 32'hAA000002;
    tick();
    bus.ImemAck = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bus.ImemAck = 1; bus.ImemData = 32'h0BAD0BAD; end
      else bus.ImemAck = 0;
      chk("t2_valid", {63'b0, bus.InstrValid}, 64'h1);
      chk("t2_instr", {32'b0, bus.Instruction}, 64'hAA000002);
      chk("t2_ipc",   bus.InstrPC, 64'h4);
      chk("t2_req",   {63'b0, bus.ImemReq}, 64'h0);
      tick();
    end
    bus.ImemAck = 0;
    chk("t2_hold_end", {32'b0, bus.Instruction}, 64'hAA000002);
    bus.DecodeReady = 1;
    tick();
    chk("t2_req1", {63'b0, bus.ImemReq}, 64'h1);
    chk("t2_addr", bus.ImemAddr, 64'h8);

    // 3: unconditional redirect while idle with a full buffer
    bus.ImemAck = 1; bus.ImemData = 32'hAA000003; bus.DecodeReady = 0;
    tick();
    bus.ImemAck = 0;
    chk("t3_ipc", bus.InstrPC, 64'h8);
    bus.BrValid = 1; bus.Uncondbranch = 1; bus.BrPC = 64'h40;
    bus.BusImm = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    clear_br();
    chk("t3_vclr", {63'b0, bus.InstrValid}, 64'h0);
    tick();
    chk("t3_addr", bus.ImemAddr, 64'h38);

    // 4: CB not taken, then CB taken
    bus.ImemAck = 1; bus.ImemData = 32'hAA000004;
    tick();
    bus.ImemAck = 0;
    chk("t4_ipc", bus.InstrPC, 64'h38);
    bus.BrValid = 1; bus.Branch = 1; bus.Zero = 0; bus.BrPC = 64'h100; bus.BusImm = 64'h5;
    bus.DecodeReady = 1;
    tick();
    clear_br();
    chk("t4_nt_addr", bus.ImemAddr, 64'h3C);
    bus.ImemAck = 1; bus.ImemData = 32'hAA000005; bus.DecodeReady = 0;
    tick();
    bus.ImemAck = 0;
    chk("t4_ipc2", bus.InstrPC, 64'h3C);
    bus.BrValid = 1; bus.Branch = 1; bus.Zero = 1; bus.BrPC = 64'h10; bus.BusImm = 64'h3;
    tick();
    clear_br();
    chk("t4_vclr", {63'b0, bus.InstrValid}, 64'h0);
    tick();
    chk("t4_t_addr", bus.ImemAddr, 64'h1C);

    // 5: redirect with fetch outstanding, ack 3 cycles late
    bus.BrValid = 1; bus.Uncondbranch = 1; bus.BrPC = 64'h200; bus.BusImm = 64'h4;
    tick();
    clear_br();
    chk("t5_drain_req",  {63'b0, bus.ImemReq}, 64'h1);
    chk("t5_drain_addr", bus.ImemAddr, 64'h1C);
    tick(); tick();
    chk("t5_hold_addr",  bus.ImemAddr, 64'h1C);
    bus.ImemAck = 1; bus.ImemData = 32'hDEADBEEF;
    tick();
    bus.ImemAck = 0;
    chk("t5_valid", {63'b0, bus.InstrValid}, 64'h0);
    chk("t5_req0",  {63'b0, bus.ImemReq}, 64'h0);
    tick();
    chk("t5_tgt",   bus.ImemAddr, 64'h210);
    chk("t5_stale", {32'b0, bus.Instruction}, 64'hAA000005);

    // 6a: reset during FETCH
    Reset = 1;
    tick();
    chk("t6a_req",   {63'b0, bus.ImemReq}, 64'h0);
    chk("t6a_addr",  bus.ImemAddr, 64'h0);
    chk("t6a_valid", {63'b0, bus.InstrValid}, 64'h0);
    Reset = 0;
    tick();
    chk("t6a_fetch", {63'b0, bus.ImemReq}, 64'h1);
    chk("t6a_pc",    bus.ImemAddr, 64'h0);

    // 6b: reset during DRAIN
    bus.BrValid = 1; bus.Uncondbranch = 1; bus.BrPC = 64'h80; bus.BusImm = 64'h1;
    tick();
    clear_br();
    chk("t6b_drain", {63'b0, bus.ImemReq}, 64'h1);
    Reset = 1;
    tick();
    chk("t6b_req",   {63'b0, bus.ImemReq}, 64'h0);
    chk("t6b_valid", {63'b0, bus.InstrValid}, 64'h0);
    Reset = 0;
    tick();
    chk("t6b_fetch", {63'b0, bus.ImemReq}, 64'h1);
    chk("t6b_pc",    bus.ImemAddr, 64'h0);
    bus.ImemAck = 1; bus.ImemData = 32'hAA000006;
    tick();
    bus.ImemAck = 0;
    chk("t6b_fill",  {32'b0, bus.Instruction}, 64'hAA000006);
    chk("t6b_ipc",   bus.InstrPC, 64'h0);
    chk("t6b_v",     {63'b0, bus.InstrValid}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
